// File: rtl/matrix_storage_pkg.sv
// Shared state encoding, request indices and default sizing for the
// matrix storage controller.
package matrix_storage_pkg;

    localparam int unsigned DEF_DATA_SIZE = 16;
    localparam int unsigned DEF_MAX_LAYER = 5;
    localparam int unsigned DEF_SIZE      = 3;

    // Bit positions of the two clients in the arbiter request/grant vectors
    localparam int unsigned REQ_WR = 0;
    localparam int unsigned REQ_RD = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_HOLD
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 is favoured on the first tie
// after reset, and priority flips to the other client on each accepted grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    logic r_prio_hi;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_prio_hi ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio_hi <= 1'b0;
        end else if (i_accept && (o_gnt != 2'b00)) begin
            r_prio_hi <= o_gnt[0];
        end
    end

endmodule

// File: rtl/matrix_storage_controller.sv
// Sequences whole-layer row loads and fetches between two clients and an
// external row storage with fixed one-cycle read latency.
module matrix_storage_controller
    import matrix_storage_pkg::*;
#(
    parameter int unsigned data_size = DEF_DATA_SIZE,
    parameter int unsigned max_layer = DEF_MAX_LAYER,
    parameter int unsigned size      = DEF_SIZE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_start,
    input  logic [31:0]               wr_layer,
    input  logic                      wr_valid,
    input  logic [data_size*size-1:0] wr_data,
    output logic                      wr_ready,
    output logic                      wr_done,
    input  logic                      rd_start,
    input  logic [31:0]               rd_layer,
    output logic                      rd_valid,
    output logic [data_size*size-1:0] rd_data,
    input  logic                      rd_ready,
    output logic                      rd_done,
    output logic                      st_is_write,
    output logic [31:0]               st_write_layer_index,
    output logic [31:0]               st_write_row_index,
    output logic [data_size*size-1:0] st_write_data,
    output logic                      st_is_read,
    output logic [31:0]               st_read_layer_index,
    output logic [31:0]               st_read_row_index,
    input  logic [data_size*size-1:0] st_read_data,
    output logic                      busy,
    output logic                      err
);

    localparam int unsigned   RW       = data_size * size;
    localparam int unsigned   CW       = (size > 1) ? $clog2(size) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(size - 1);
    localparam logic [31:0]   LAYERS   = 32'(max_layer);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_row, w_row_nxt;
    logic [31:0]   r_layer, w_layer_nxt;
    logic [RW-1:0] r_rd_data, w_rd_data_nxt;
    logic          r_wr_done, w_wr_done_nxt;
    logic          r_rd_done, w_rd_done_nxt;
    logic          r_err, w_err_nxt;
    logic          w_wr_ok, w_rd_ok, w_accept;
    logic [1:0]    w_req, w_gnt;

    assign w_wr_ok  = wr_start && (wr_layer < LAYERS);
    assign w_rd_ok  = rd_start && (rd_layer < LAYERS);
    assign w_accept = (r_state == ST_IDLE);

    always_comb begin
        w_req         = '0;
        w_req[REQ_WR] = w_wr_ok;
        w_req[REQ_RD] = w_rd_ok;
    end

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req    (w_req),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_row     <= '0;
            r_layer   <= '0;
            r_rd_data <= '0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_layer   <= w_layer_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_wr_done <= w_wr_done_nxt;
            r_rd_done <= w_rd_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_row_nxt            = r_row;
        w_layer_nxt          = r_layer;
        w_rd_data_nxt        = r_rd_data;
        w_wr_done_nxt        = 1'b0;
        w_rd_done_nxt        = 1'b0;
        w_err_nxt            = 1'b0;
        wr_ready             = 1'b0;
        rd_valid             = 1'b0;
        st_is_write          = 1'b0;
        st_write_layer_index = '0;
        st_write_row_index   = '0;
        st_write_data        = '0;
        st_is_read           = 1'b0;
        st_read_layer_index  = '0;
        st_read_row_index    = '0;

        case (r_state)
            ST_IDLE: begin
                w_err_nxt = (wr_start && !w_wr_ok) || (rd_start && !w_rd_ok);
                w_row_nxt = '0;
                if (w_gnt[REQ_WR]) begin
                    w_state_nxt = ST_WRITE;
                    w_layer_nxt = wr_layer;
                end else if (w_gnt[REQ_RD]) begin
                    w_state_nxt = ST_RD_ISSUE;
                    w_layer_nxt = rd_layer;
                end
            end
            ST_WRITE: begin
                wr_ready             = 1'b1;
                st_is_write          = wr_valid;
                st_write_data        = wr_data;
                st_write_row_index   = 32'(r_row);
                st_write_layer_index = r_layer;
                if (wr_valid) begin
                    if (r_row == LAST_ROW) begin
                        w_state_nxt   = ST_IDLE;
                        w_row_nxt     = '0;
                        w_wr_done_nxt = 1'b1;
                    end else begin
                        w_row_nxt = r_row + 1'b1;
                    end
                end
            end
            ST_RD_ISSUE: begin
                st_is_read          = 1'b1;
                st_read_row_index   = 32'(r_row);
                st_read_layer_index = r_layer;
                w_state_nxt         = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_rd_data_nxt = st_read_data;
                w_state_nxt   = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    if (r_row == LAST_ROW) begin
                        w_state_nxt   = ST_IDLE;
                        w_row_nxt     = '0;
                        w_rd_done_nxt = 1'b1;
                    end else begin
                        w_row_nxt   = r_row + 1'b1;
                        w_state_nxt = ST_RD_ISSUE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Strobes and write acceptance are suppressed while reset is held
        if (reset) begin
            wr_ready    = 1'b0;
            st_is_write = 1'b0;
            st_is_read  = 1'b0;
        end
    end

    assign rd_data = r_rd_data;
    assign wr_done = r_wr_done;
    assign rd_done = r_rd_done;
    assign err     = r_err;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_matrix_storage_controller.sv
// Self-checking bench: table-driven start arbitration, directed corner
// sequences and randomized loads/fetches against a layer/row reference memory.
module tb_matrix_storage_controller;
    import matrix_storage_pkg::*;

    localparam int unsigned DW   = DEF_DATA_SIZE;
    localparam int unsigned MAXL = DEF_MAX_LAYER;
    localparam int unsigned SIZE = DEF_SIZE;
    localparam int unsigned RW   = DW * SIZE;

    logic          clk, reset;
    logic          wr_start, wr_valid, wr_ready, wr_done;
    logic          rd_start, rd_valid, rd_ready, rd_done;
    logic          st_is_write, st_is_read, busy, err;
    logic [31:0]   wr_layer, rd_layer;
    logic [31:0]   st_write_layer_index, st_write_row_index;
    logic [31:0]   st_read_layer_index, st_read_row_index;
    logic [RW-1:0] wr_data, rd_data, st_write_data, st_read_data;

    matrix_storage_controller #(
        .data_size (DW),
        .max_layer (MAXL),
        .size      (SIZE)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .wr_start             (wr_start),
        .wr_layer             (wr_layer),
        .wr_valid             (wr_valid),
        .wr_data              (wr_data),
        .wr_ready             (wr_ready),
        .wr_done              (wr_done),
        .rd_start             (rd_start),
        .rd_layer             (rd_layer),
        .rd_valid             (rd_valid),
        .rd_data              (rd_data),
        .rd_ready             (rd_ready),
        .rd_done              (rd_done),
        .st_is_write          (st_is_write),
        .st_write_layer_index (st_write_layer_index),
        .st_write_row_index   (st_write_row_index),
        .st_write_data        (st_write_data),
        .st_is_read           (st_is_read),
        .st_read_layer_index  (st_read_layer_index),
        .st_read_row_index    (st_read_row_index),
        .st_read_data         (st_read_data),
        .busy                 (busy),
        .err                  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External storage: one-cycle read latency
    logic [RW-1:0] store [MAXL][SIZE];
    always @(posedge clk) begin
        if (st_is_write && st_write_layer_index < MAXL && st_write_row_index < SIZE)
            store[st_write_layer_index[2:0]][st_write_row_index[1:0]] <= st_write_data;
        if (st_is_read && st_read_layer_index < MAXL && st_read_row_index < SIZE)
            st_read_data <= store[st_read_layer_index[2:0]][st_read_row_index[1:0]];
    end

    // Protocol invariants sampled every cycle
    int unsigned mon_viol = 0;
    always @(negedge clk) begin
        if ((st_is_write && st_is_read) ||
            (reset && (st_is_write || st_is_read)) ||
            (st_is_write && st_write_row_index >= SIZE) ||
            (st_is_read && st_read_row_index >= SIZE) ||
            (!busy && (st_is_write || st_is_read)))
            mon_viol <= mon_viol + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int unsigned   n_chk = 0;
    int unsigned   n_err = 0;
    logic [RW-1:0] ref_mem [MAXL][SIZE];
    logic [RW-1:0] wdata [SIZE];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({busy, err, wr_ready, wr_done, rd_valid, rd_done,
                                   st_is_write, st_is_read}), 64'(0));
        check({tag, "_rd_data"}, 64'(rd_data), 64'(0));
        check({tag, "_st_wdata"}, 64'(st_write_data), 64'(0));
        check({tag, "_st_waddr"}, {st_write_layer_index, st_write_row_index}, 64'(0));
        check({tag, "_st_raddr"}, {st_read_layer_index, st_read_row_index}, 64'(0));
    endtask

    task automatic drive_junk(input bit en);
        if (en && ($urandom_range(0, 2) == 0)) begin
            wr_start = 1'($urandom_range(0, 1));
            rd_start = 1'($urandom_range(0, 1));
            wr_layer = $urandom_range(0, 7);
            rd_layer = $urandom_range(0, 7);
        end else begin
            wr_start = 1'b0;
            rd_start = 1'b0;
        end
    endtask

    task automatic start_op(input bit ws, input logic [31:0] wl, input bit rs, input logic [31:0] rl);
        wr_start = ws; wr_layer = wl; rd_start = rs; rd_layer = rl;
        wr_valid = 1'b0; rd_ready = 1'b0;
        cyc();
        wr_start = 1'b0; rd_start = 1'b0;
    endtask

    // Called in the first cycle after a granted write start
    task automatic write_rows(input logic [31:0] layer, input int unsigned max_gap,
                              input bit junk, input bit fixed, input bit exp_err0);
        int unsigned gap;
        logic        exp_e;
        exp_e = exp_err0;
        for (int k = 0; k < SIZE; k++) begin
            if (!fixed) wdata[k] = RW'({$urandom(), $urandom()});
            gap = (max_gap == 0) ? 0 : $urandom_range(0, max_gap);
            repeat (gap) begin
                wr_valid = 1'b0;
                wr_data  = RW'({$urandom(), $urandom()});
                drive_junk(junk);
                #1;
                check("wr_gap", 64'({st_is_write, wr_ready, busy, err, wr_done}),
                      64'({1'b0, 1'b1, 1'b1, exp_e, 1'b0}));
                exp_e = 1'b0;
                cyc();
            end
            wr_valid = 1'b1;
            wr_data  = wdata[k];
            drive_junk(junk);
            #1;
            check("wr_strobe", 64'({st_is_write, wr_ready, busy, err, wr_done}),
                  64'({1'b1, 1'b1, 1'b1, exp_e, 1'b0}));
            check("wr_row", 64'(st_write_row_index), 64'(k));
            check("wr_layer", 64'(st_write_layer_index), 64'(layer));
            check("wr_data", 64'(st_write_data), 64'(wdata[k]));
            ref_mem[layer[2:0]][k[1:0]] = wdata[k];
            exp_e = 1'b0;
            cyc();
        end
        wr_valid = 1'b0; wr_start = 1'b0; rd_start = 1'b0;
        #1;
        check("wr_done", 64'({wr_done, busy, wr_ready, err, st_is_write}), 64'(5'b10000));
        cyc();
        check("wr_done_once", 64'({wr_done, busy}), 64'(0));
    endtask

    // Called in the first cycle after a granted read start
    task automatic read_rows(input logic [31:0] layer, input int unsigned s0,
                             input int unsigned s1, input int unsigned s2,
                             input bit junk, input bit exp_err0);
        int unsigned stl [3];
        logic        exp_e;
        stl[0] = s0; stl[1] = s1; stl[2] = s2;
        exp_e = exp_err0;
        for (int k = 0; k < SIZE; k++) begin
            rd_ready = 1'b0;
            drive_junk(junk);
            #1;
            check("rd_issue", 64'({st_is_read, st_is_write, rd_valid, err, rd_done, busy}),
                  64'({1'b1, 1'b0, 1'b0, exp_e, 1'b0, 1'b1}));
            check("rd_issue_row", 64'(st_read_row_index), 64'(k));
            check("rd_issue_layer", 64'(st_read_layer_index), 64'(layer));
            exp_e = 1'b0;
            cyc();
            drive_junk(junk);
            #1;
            check("rd_wait", 64'({st_is_read, st_is_write, rd_valid, err, rd_done, busy}),
                  64'(6'b000001));
            cyc();
            repeat (stl[k]) begin
                drive_junk(junk);
                #1;
                check("rd_stall", 64'({st_is_read, rd_valid, err, busy}), 64'(4'b0101));
                check("rd_stall_data", 64'(rd_data), 64'(ref_mem[layer[2:0]][k[1:0]]));
                cyc();
            end
            rd_ready = 1'b1;
            drive_junk(junk);
            #1;
            check("rd_hold", 64'({st_is_read, rd_valid, rd_done, err}), 64'(4'b0100));
            check("rd_data", 64'(rd_data), 64'(ref_mem[layer[2:0]][k[1:0]]));
            cyc();
        end
        rd_ready = 1'b0; wr_start = 1'b0; rd_start = 1'b0;
        #1;
        check("rd_done", 64'({rd_done, rd_valid, busy, err, st_is_read}), 64'(5'b10000));
        cyc();
        check("rd_done_once", 64'({rd_done, busy}), 64'(0));
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && busy; i++) begin
            wr_valid = 1'b1; rd_ready = 1'b1;
            cyc();
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
        check("idle_after_op", 64'(busy), 64'(0));
    endtask

    typedef struct {
        bit          ws;
        logic [31:0] wl;
        bit          rs;
        logic [31:0] rl;
        bit          exp_err;
        int unsigned exp_gnt;   // 0 none, 1 write, 2 read
    } vec_t;

    vec_t vecs [12];

    initial begin
        int unsigned lay;
        bit          op;

        vecs[0]  = '{1'b1, 32'd0, 1'b0, 32'd0, 1'b0, 1};
        vecs[1]  = '{1'b1, 32'd1, 1'b1, 32'd2, 1'b0, 2};
        vecs[2]  = '{1'b1, 32'd3, 1'b1, 32'd4, 1'b0, 1};
        vecs[3]  = '{1'b1, 32'd5, 1'b0, 32'd0, 1'b1, 0};
        vecs[4]  = '{1'b0, 32'd0, 1'b1, 32'd7, 1'b1, 0};
        vecs[5]  = '{1'b1, 32'd5, 1'b1, 32'd3, 1'b1, 2};
        vecs[6]  = '{1'b1, 32'd4, 1'b1, 32'd4, 1'b0, 1};
        vecs[7]  = '{1'b0, 32'd0, 1'b1, 32'd4, 1'b0, 2};
        vecs[8]  = '{1'b1, 32'd4, 1'b1, 32'd99, 1'b1, 1};
        vecs[9]  = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 0};
        vecs[10] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1, 0};
        vecs[11] = '{1'b1, 32'd4, 1'b1, 32'd4, 1'b0, 2};

        reset = 1'b1;
        wr_start = 1'b0; rd_start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        wr_layer = '0; rd_layer = '0;
        wr_data  = RW'(48'hA5A5_5A5A_F00F);
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        check_all_zero("reset");

        // Fixed three-row load of layer 2, wr_valid held high
        wdata[0] = RW'(48'h0001_0002_0003);
        wdata[1] = RW'(48'h0004_0005_0006);
        wdata[2] = RW'(48'h0007_0008_0009);
        start_op(1'b1, 32'd2, 1'b0, 32'd0);
        write_rows(32'd2, 0, 1'b0, 1'b1, 1'b0);

        for (int l = 0; l < MAXL; l++) begin
            if (l != 2) begin
                start_op(1'b1, 32'(l), 1'b0, 32'd0);
                write_rows(32'(l), 1, 1'b0, 1'b0, 1'b0);
            end
        end

        // Back-to-back fetch, then a 5-cycle consumer stall on row 1
        start_op(1'b0, 32'd0, 1'b1, 32'd2);
        read_rows(32'd2, 0, 0, 0, 1'b0, 1'b0);
        start_op(1'b0, 32'd0, 1'b1, 32'd2);
        read_rows(32'd2, 0, 5, 0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].ws, vecs[i].wl, vecs[i].rs, vecs[i].rl);
            #1;
            check("vec_err", 64'(err), 64'(vecs[i].exp_err));
            check("vec_grant", 64'({wr_ready, st_is_read, busy}),
                  64'((vecs[i].exp_gnt == 1) ? 3'b101 : (vecs[i].exp_gnt == 2) ? 3'b011 : 3'b000));
            if (vecs[i].exp_gnt == 1) begin
                write_rows(vecs[i].wl, 1, 1'b0, 1'b0, vecs[i].exp_err);
            end else if (vecs[i].exp_gnt == 2) begin
                read_rows(vecs[i].rl, 1, 0, 2, 1'b0, vecs[i].exp_err);
            end else begin
                cyc();
                check("vec_err_pulse", 64'({err, busy}), 64'(0));
            end
            drain();
        end

        // Reset mid-write: no strobe while reset is high, then simultaneous starts
        start_op(1'b1, 32'd0, 1'b0, 32'd0);
        wr_valid = 1'b1;
        wr_data  = RW'(48'hDEAD_BEEF_0001);
        reset    = 1'b1;
        #1;
        check("reset_strobe_wr", 64'({st_is_write, st_is_read, wr_ready}), 64'(0));
        cyc();
        reset = 1'b0; wr_valid = 1'b0;
        #1;
        check_all_zero("reset_mid_wr");
        start_op(1'b1, 32'd1, 1'b1, 32'd2);
        #1;
        check("tie1_write", 64'({wr_ready, st_is_read, busy}), 64'(3'b101));
        write_rows(32'd1, 0, 1'b0, 1'b0, 1'b0);
        start_op(1'b1, 32'd3, 1'b1, 32'd1);
        #1;
        check("tie2_read", 64'({wr_ready, st_is_read, busy}), 64'(3'b011));
        read_rows(32'd1, 0, 0, 0, 1'b0, 1'b0);
        start_op(1'b1, 32'd5, 1'b0, 32'd0);
        #1;
        check("bad_layer_err", 64'({err, busy}), 64'(2'b10));
        cyc();
        check("bad_layer_after", 64'({err, busy}), 64'(0));

        // Reset during RD_HOLD of row 1, then a fresh fetch
        start_op(1'b0, 32'd0, 1'b1, 32'd2);
        cyc();
        cyc();
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        cyc();
        cyc();
        check("hold_row1", 64'({rd_valid, busy}), 64'(2'b11));
        check("hold_row1_data", 64'(rd_data), 64'(ref_mem[2][1]));
        reset = 1'b1;
        #1;
        check("reset_strobe_rd", 64'({st_is_write, st_is_read}), 64'(0));
        cyc();
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid_rd");
        cyc();
        check("no_late_done", 64'({rd_done, busy}), 64'(0));
        start_op(1'b0, 32'd0, 1'b1, 32'd2);
        read_rows(32'd2, 0, 0, 0, 1'b0, 1'b0);

        // Randomized single-client traffic with stray starts during operations
        for (int i = 0; i < 40; i++) begin
            op  = 1'($urandom_range(0, 1));
            lay = $urandom_range(0, MAXL + 1);
            if (op) start_op(1'b1, 32'(lay), 1'b0, 32'd0);
            else    start_op(1'b0, 32'd0, 1'b1, 32'(lay));
            if (lay >= MAXL) begin
                #1;
                check("rand_reject", 64'({err, busy}), 64'(2'b10));
                cyc();
                check("rand_reject_after", 64'({err, busy}), 64'(0));
            end else if (op) begin
                write_rows(32'(lay), 2, 1'b1, 1'b0, 1'b0);
            end else begin
                read_rows(32'(lay), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), 1'b1, 1'b0);
            end
            drain();
        end

        check("invariants", 64'(mon_viol), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/matrix_storage_controller.md
MATRIX_STORAGE_CONTROLLER -- requirements
Module: matrix_storage_controller

Interface
REQ-001 SHALL have parameter data_size, default 16: bits per matrix element.
REQ-002 SHALL have parameter max_layer, default 5: number of layers in storage; valid layer indices are 0..max_layer-1.
REQ-003 SHALL have parameter size, default 3: rows per layer and elements per row; one row is data_size*size bits.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have write-client ports: wr_start in 1, start layer load; wr_layer in 32, target layer; wr_valid in 1, row offered; wr_data in data_size*size, row payload; wr_ready out 1, row accepted; wr_done out 1, load-complete pulse.
REQ-007 SHALL have read-client ports: rd_start in 1, start layer fetch; rd_layer in 32, source layer; rd_valid out 1, row presented; rd_data out data_size*size, row payload; rd_ready in 1, consumer accepts; rd_done out 1, fetch-complete pulse.
REQ-008 SHALL have storage-side ports: st_is_write out 1; st_write_layer_index out 32; st_write_row_index out 32; st_write_data out data_size*size; st_is_read out 1; st_read_layer_index out 32; st_read_row_index out 32; st_read_data in data_size*size.
REQ-009 SHALL have status ports: busy out 1, not in IDLE; err out 1, one-cycle pulse on rejected start.

Function
REQ-010 SHALL implement FSM states IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD, with a row counter 0..size-1 and a latched layer register.
REQ-011 In IDLE, a start whose layer is >= max_layer SHALL be rejected: err=1 next cycle, state stays IDLE.
REQ-012 In IDLE, if exactly one valid start is present, that start SHALL be granted; the FSM enters WRITE or RD_ISSUE next cycle with the counter at 0.
REQ-013 If wr_start and rd_start are both valid in the same IDLE cycle, the client not granted last SHALL win (round-robin); the write client SHALL win the first tie after reset; the loser is dropped and must re-assert.
REQ-014 Starts arriving outside IDLE SHALL be ignored with no err.
REQ-015 In WRITE, wr_ready SHALL be 1; st_is_write SHALL equal wr_valid combinationally; st_write_data SHALL equal wr_data; st_write_row_index SHALL equal the counter; st_write_layer_index SHALL equal the latched layer.
REQ-016 Each wr_valid&&wr_ready cycle SHALL increment the counter. The handshake at counter size-1 SHALL return the FSM to IDLE and pulse wr_done for the following cycle.
REQ-017 Storage read latency is fixed at one cycle: st_read_data is valid the cycle after st_is_read.
REQ-018 RD_ISSUE SHALL drive st_is_read=1 for one cycle, with row = counter and layer = latched layer, then go to RD_WAIT.
REQ-019 RD_WAIT SHALL register st_read_data into rd_data, then go to RD_HOLD.
REQ-020 In RD_HOLD, rd_valid SHALL be 1 and rd_data SHALL be stable until rd_ready. On rd_ready at counter < size-1, the counter SHALL increment and the FSM go to RD_ISSUE. On rd_ready at counter size-1, the FSM SHALL go to IDLE and pulse rd_done the following cycle.
REQ-021 st_is_write and st_is_read SHALL never both be 1, and SHALL be 0 in IDLE.
REQ-022 Row indices SHALL never reach size; the counter SHALL not wrap within an operation.

Reset
REQ-023 Reset, including reset mid-operation, SHALL force: state IDLE, counter 0, latched layer 0, round-robin pointer "write next", all outputs 0 (including rd_data).
REQ-024 No storage strobe SHALL assert in any cycle where reset is 1; an aborted operation emits no done pulse.

Structure
REQ-025 FSM state encoding and the default parameter values SHALL live in the shared package matrix_storage_pkg.
REQ-026 Round-robin tie-break logic SHALL be a sub-module, rr_arbiter2: 2 requests, 1-hot grant, update on accept.
REQ-027 The block SHALL contain no storage array; the address datapath is the counter plus the layer register only.

Verification
REQ-028 Load layer 2 with rows 0x0001_0002_0003, 0x0004_0005_0006, 0x0007_0008_0009, wr_valid held high -> three st_is_write cycles at rows 0,1,2, layer 2; wr_done pulses once, in the cycle after the third write.
REQ-029 Fetch layer 2 with rd_ready=1 against a 1-cycle-latency storage model -> rd_data shows the three rows in order, each 3 cycles apart; rd_done follows the last.
REQ-030 Fetch with rd_ready low for 5 cycles on row 1 -> rd_valid held, rd_data unchanged, no extra st_is_read.
REQ-031 wr_start and rd_start together twice, both valid -> write first, then read after the requesters re-assert; wr_layer=5 -> err pulse, busy stays 0.
REQ-032 Assert reset during RD_HOLD of row 1 -> next cycle: all outputs 0, IDLE, no rd_done; a fresh fetch starts at row 0.
